cardinal_nic: RTL and testbench

- Network interface controller between a tile's processing element (PE) and its local router port.
- Holds one 64-bit injection buffer (PE -> router) and one 64-bit ejection buffer (router -> PE), both memory-mapped to the PE.
- Enforces the router's odd/even VC polarity on injection.
- Its injection-side and PE-read-side signals are the ones the tile's packet snoop logger taps.

---
 rtl/cardinal_nic.sv | 141 ++++++++++++++
 tb/tb_cardinal_nic.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// cardinal_nic -- network interface between a tile's processing element (PE)
// and its local router port. One 64-bit ejection buffer (router -> PE) and
// one 64-bit injection buffer (PE -> router), both memory-mapped to the PE.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   nic_addr        PE register select: 00 ej buf, 01 ej status,
//                   10 inj buf, 11 inj status
//   nic_en          PE access strobe
//   nic_wr_en       1 = write, 0 = read (qualified by nic_en)
//   pe_to_nic_data  PE write data
//   nic_to_pe_data  PE read data (combinational, 0 when no read)
//   net_so/net_ro   injection valid / router ready
//   net_do          injection packet (always the injection buffer)
//   net_polarity    router VC phase; packet leaves only when bit 63 matches
//   net_si/net_ri   ejection valid / NIC ready
//   net_di          ejection packet
module cardinal_nic #(
   parameter int TILE_X    = 0,
   parameter int TILE_Y    = 0,
   parameter bit STAMP_SRC = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  nic_addr,
   input  logic        nic_en,
   input  logic        nic_wr_en,
   input  logic [63:0] pe_to_nic_data,
   output logic [63:0] nic_to_pe_data,
   output logic        net_so,
   input  logic        net_ro,
   output logic [63:0] net_do,
   input  logic        net_polarity,
   input  logic        net_si,
   output logic        net_ri,
   input  logic [63:0] net_di
);

   localparam logic [1:0] ADDR_EJ_BUF  = 2'b00;
   localparam logic [1:0] ADDR_EJ_STAT = 2'b01;
   localparam logic [1:0] ADDR_IN_BUF  = 2'b10;
   localparam logic [1:0] ADDR_IN_STAT = 2'b11;

   localparam logic [7:0] SRC_X = 8'(TILE_X);
   localparam logic [7:0] SRC_Y = 8'(TILE_Y);

   // "in" = ejection side (router -> PE), "out" = injection side (PE -> router)
   logic [63:0] in_buf_q,  in_buf_d;
   logic        in_full_q, in_full_d;
   logic [63:0] out_buf_q, out_buf_d;
   logic        out_full_q, out_full_d;
   logic        out_drop_q, out_drop_d;

   logic        pe_rd, pe_wr;
   logic [63:0] wr_word;

   assign pe_rd = nic_en && !nic_wr_en;
   assign pe_wr = nic_en &&  nic_wr_en;

   // Source coordinates are stamped into the header on the way into the buffer.
   always_comb begin
      wr_word = pe_to_nic_data;
      if (STAMP_SRC) begin
         wr_word[47:40] = SRC_X;
         wr_word[39:32] = SRC_Y;
      end
   end

   assign net_ri = ~in_full_q;
   assign net_so = out_full_q && (out_buf_q[63] == net_polarity);
   assign net_do = out_buf_q;

   always_comb begin
      nic_to_pe_data = '0;
      if (pe_rd) begin
         unique case (nic_addr)
            ADDR_EJ_BUF:  nic_to_pe_data = in_buf_q;
            ADDR_EJ_STAT: nic_to_pe_data = {63'b0, in_full_q};
            ADDR_IN_BUF:  nic_to_pe_data = '0;
            ADDR_IN_STAT: nic_to_pe_data = {62'b0, out_drop_q, out_full_q};
            default:      nic_to_pe_data = '0;
         endcase
      end
   end

   always_comb begin
      in_buf_d   = in_buf_q;
      in_full_d  = in_full_q;
      out_buf_d  = out_buf_q;
      out_full_d = out_full_q;
      out_drop_d = out_drop_q;

      // Ejection: capture only while empty; a PE read of a full buffer frees it.
      // Capture and read-clear are mutually exclusive because they depend on
      // opposite values of in_full_q.
      if (in_full_q) begin
         if (pe_rd && nic_addr == ADDR_EJ_BUF)
            in_full_d = 1'b0;
      end else if (net_si) begin
         in_buf_d  = net_di;
         in_full_d = 1'b1;
      end

      // Injection handshake.
      if (net_so && net_ro)
         out_full_d = 1'b0;

      // Status read clears the sticky drop flag; a drop in the same cycle wins.
      if (pe_rd && nic_addr == ADDR_IN_STAT)
         out_drop_d = 1'b0;

      // Acceptance looks at the registered out_full, so a write while full is
      // dropped even if the handshake frees the buffer at this same edge.
      if (pe_wr && nic_addr == ADDR_IN_BUF) begin
         if (!out_full_q) begin
            out_buf_d  = wr_word;
            out_full_d = 1'b1;
         end else begin
            out_drop_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_buf_q   <= '0;
         in_full_q  <= 1'b0;
         out_buf_q  <= '0;
         out_full_q <= 1'b0;
         out_drop_q <= 1'b0;
      end else begin
         in_buf_q   <= in_buf_d;
         in_full_q  <= in_full_d;
         out_buf_q  <= out_buf_d;
         out_full_q <= out_full_d;
         out_drop_q <= out_drop_d;
      end
   end

endmodule

// File: tb/tb_cardinal_nic.sv
module tb_cardinal_nic;

   logic        clk;
   logic        reset;
   logic [1:0]  nic_addr;
   logic        nic_en;
   logic        nic_wr_en;
   logic [63:0] pe_to_nic_data;
   logic [63:0] nic_to_pe_data;
   logic        net_so;
   logic        net_ro;
   logic [63:0] net_do;
   logic        net_polarity;
   logic        net_si;
   logic        net_ri;
   logic [63:0] net_di;

   int checks = 0;
   int errors = 0;

   logic [63:0] rd_q[$];
   logic [63:0] inj_q[$];

   cardinal_nic #(
      .TILE_X    (2),
      .TILE_Y    (3),
      .STAMP_SRC (1'b1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .nic_addr       (nic_addr),
      .nic_en         (nic_en),
      .nic_wr_en      (nic_wr_en),
      .pe_to_nic_data (pe_to_nic_data),
      .nic_to_pe_data (nic_to_pe_data),
      .net_so         (net_so),
      .net_ro         (net_ro),
      .net_do         (net_do),
      .net_polarity   (net_polarity),
      .net_si         (net_si),
      .net_ri         (net_ri),
      .net_di         (net_di)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: PE reads and injection handshakes are scored against queues.
   always @(negedge clk) begin
      if (reset && nic_en && !nic_wr_en) begin
         if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read got %h expected none", nic_to_pe_data);
         end else begin
            chk("pe_read", nic_to_pe_data, rd_q.pop_front());
         end
      end
      if (reset && net_so && net_ro) begin
         if (inj_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_inject got %h expected none", net_do);
         end else begin
            chk("inject", net_do, inj_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; drives one access cycle, returns at next posedge+1.
   task automatic pe_read(input logic [1:0] a, input logic [63:0] exp);
      rd_q.push_back(exp);
      nic_en = 1'b1; nic_wr_en = 1'b0; nic_addr = a;
      step();
      nic_en = 1'b0;
   endtask

   task automatic pe_write(input logic [1:0] a, input logic [63:0] d);
      nic_en = 1'b1; nic_wr_en = 1'b1; nic_addr = a; pe_to_nic_data = d;
      step();
      nic_en = 1'b0; nic_wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b0; nic_addr = 2'b00; nic_en = 1'b0; nic_wr_en = 1'b0;
      pe_to_nic_data = '0; net_ro = 1'b0; net_polarity = 1'b0;
      net_si = 1'b0; net_di = '0;

      // Reset state
      #2;
      chk("rst_ri", {63'b0, net_ri}, 64'd1);
      chk("rst_so", {63'b0, net_so}, 64'd0);
      chk("rst_do", net_do, 64'd0);
      chk("rst_rdata", nic_to_pe_data, 64'd0);
      step(); step();
      reset = 1'b1;
      step();

      pe_read(2'b01, 64'd0);
      pe_read(2'b11, 64'd0);
      pe_read(2'b10, 64'd0);
      chk("idle_rdata", nic_to_pe_data, 64'd0);

      // Stamped injection, polarity match, router ready
      net_polarity = 1'b0; net_ro = 1'b1;
      inj_q.push_back(64'h0000_0203_DEAD_BEEF);
      pe_write(2'b10, 64'h0000_0000_DEAD_BEEF);
      chk("inj1_so", {63'b0, net_so}, 64'd1);
      chk("inj1_do", net_do, 64'h0000_0203_DEAD_BEEF);
      step();
      pe_read(2'b11, 64'd0);

      // Polarity stall: vc=1 with polarity 0 for 5 cycles
      pe_write(2'b10, 64'h8000_FFFF_1234_5678);
      for (int unsigned i = 0; i < 5; i++) begin
         chk("pol_stall_so", {63'b0, net_so}, 64'd0);
         step();
      end
      inj_q.push_back(64'h8000_0203_1234_5678);
      net_polarity = 1'b1;
      #1;
      chk("pol_go_so", {63'b0, net_so}, 64'd1);
      step();
      net_polarity = 1'b0;
      chk("pol_done_so", {63'b0, net_so}, 64'd0);

      // Drop on write while full
      net_ro = 1'b0;
      pe_write(2'b10, 64'h0000_0000_0000_00AA);
      pe_write(2'b10, 64'h0000_0000_0000_00BB);
      chk("drop_do", net_do, 64'h0000_0203_0000_00AA);
      pe_read(2'b11, 64'd3);
      pe_read(2'b11, 64'd1);
      inj_q.push_back(64'h0000_0203_0000_00AA);
      net_ro = 1'b1;
      step();
      net_ro = 1'b0;
      pe_read(2'b11, 64'd0);

      // Ejection capture, ignore-while-full, read, release
      net_si = 1'b1; net_di = 64'h8000_0000_0000_0001;
      step();
      net_di = 64'hFFFF_FFFF_FFFF_FFFF;
      chk("ej_ri_full", {63'b0, net_ri}, 64'd0);
      step();
      net_si = 1'b0;
      pe_read(2'b01, 64'd1);
      pe_read(2'b00, 64'h8000_0000_0000_0001);
      chk("ej_ri_free", {63'b0, net_ri}, 64'd1);
      pe_read(2'b01, 64'd0);
      pe_read(2'b00, 64'h8000_0000_0000_0001);
      pe_write(2'b00, 64'h1111_2222_3333_4444);
      pe_read(2'b00, 64'h8000_0000_0000_0001);

      // Asynchronous reset with both buffers full
      pe_write(2'b10, 64'h0000_0000_0000_0CC0);
      net_si = 1'b1; net_di = 64'h0000_0000_0000_0055;
      step();
      net_si = 1'b0;
      chk("pre_rst_so", {63'b0, net_so}, 64'd1);
      chk("pre_rst_ri", {63'b0, net_ri}, 64'd0);
      #2 reset = 1'b0;
      #1;
      chk("arst_so", {63'b0, net_so}, 64'd0);
      chk("arst_ri", {63'b0, net_ri}, 64'd1);
      chk("arst_do", net_do, 64'd0);
      step();
      reset = 1'b1;
      step();
      pe_read(2'b00, 64'd0);
      pe_read(2'b11, 64'd0);

      // Drain scoreboard with a bounded wait
      for (int unsigned i = 0; i < 20 && (rd_q.size() != 0 || inj_q.size() != 0); i++)
         step();
      chk("sb_rd_left", 64'(rd_q.size()), 64'd0);
      chk("sb_inj_left", 64'(inj_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
